// File: rtl/sparrow_dmem_responder.sv
// sparrow_dmem_responder
//   Slave end of the core's dmem request interface, backed by a word-organised
//   SRAM. Accepts one load/store per grant, performs byte/half/word access and
//   returns extended load data after a fixed LATENCY (1..4 cycles).
//
// Ports
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   dmem_req_i            request valid, held with its fields until granted
//   dmem_gnt_o            request accepted this cycle (combinational)
//   dmem_addr_i           byte address
//   dmem_wr_en_i          1 = store, 0 = load
//   dmem_byte_en_i        size: 00 byte, 01 half, 11 word, 10 illegal
//   dmem_zero_extend_i    loads: 1 = zero-extend, 0 = sign-extend
//   dmem_wdata_i          store data, LSB-aligned
//   dmem_rvalid_o         one-cycle response pulse per granted request
//   dmem_rdata_o          extended load data; 0 for stores, errors, idle
//   dmem_err_o            response error, qualified by rvalid
module sparrow_dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        dmem_req_i,
  output logic        dmem_gnt_o,
  input  logic [31:0] dmem_addr_i,
  input  logic        dmem_wr_en_i,
  input  logic [1:0]  dmem_byte_en_i,
  input  logic        dmem_zero_extend_i,
  input  logic [31:0] dmem_wdata_i,
  output logic        dmem_rvalid_o,
  output logic [31:0] dmem_rdata_o,
  output logic        dmem_err_o
);

  localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        rvalid_q, rvalid_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic [31:0] res_data_q, res_data_d;
  logic        res_err_q, res_err_d;

  logic [31:0] mem_q [DEPTH_WORDS];

  logic             gnt;
  logic             req_err;
  logic             mem_we;
  logic [IDX_W-1:0] word_idx;
  logic [31:0]      rd_word;
  logic [3:0]       lane_mask;
  logic [31:0]      wdata_rep;

  // Access legality: illegal size, misalignment, or word index beyond the RAM.
  function automatic logic access_err(input logic [31:0] addr, input logic [1:0] size);
    logic e;
    e = 1'b0;
    if (size == 2'b10) e = 1'b1;
    if ((size == 2'b01) && addr[0]) e = 1'b1;
    if ((size == 2'b11) && (addr[1:0] != 2'b00)) e = 1'b1;
    if ({2'b00, addr[31:2]} >= DEPTH_WORDS) e = 1'b1;
    return e;
  endfunction

  // Lane select plus sign/zero extension of a load.
  function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] size,
                                              input logic [1:0] lane, input logic zext);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (lane)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = lane[1] ? word[31:16] : word[15:0];
    case (size)
      2'b00:   r = zext ? {24'h0, b} : {{24{b[7]}}, b};
      2'b01:   r = zext ? {16'h0, h} : {{16{h[15]}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

  // Byte-lane write mask for a store of the given size at the given offset.
  function automatic logic [3:0] store_mask(input logic [1:0] size, input logic [1:0] lane);
    logic [3:0] m;
    case (size)
      2'b00:   m = 4'b0001 << lane;
      2'b01:   m = lane[1] ? 4'b1100 : 4'b0011;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

  // Request decode: grant only while able to take a new request and out of reset.
  assign gnt        = dmem_req_i & rst_n & ((state_q == ST_IDLE) || (state_q == ST_RESP));
  assign dmem_gnt_o = gnt;
  assign req_err    = access_err(dmem_addr_i, dmem_byte_en_i);
  assign word_idx   = dmem_addr_i[IDX_W+1:2];
  assign rd_word    = mem_q[word_idx];
  assign lane_mask  = store_mask(dmem_byte_en_i, dmem_addr_i[1:0]);
  // Replicating the LSB-aligned data lets the lane mask pick the right copy.
  assign wdata_rep  = (dmem_byte_en_i == 2'b00) ? {4{dmem_wdata_i[7:0]}} :
                      (dmem_byte_en_i == 2'b01) ? {2{dmem_wdata_i[15:0]}} : dmem_wdata_i;
  assign mem_we     = gnt & dmem_wr_en_i & ~req_err;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    res_data_d = res_data_q;
    res_err_d  = res_err_q;
    rvalid_d   = 1'b0;
    rdata_d    = 32'h0;
    err_d      = 1'b0;
    case (state_q)
      ST_IDLE, ST_RESP: begin
        if (gnt) begin
          // Result is formed at the grant edge from the current RAM word, so a
          // store committed on the previous edge is already visible.
          res_err_d  = req_err;
          res_data_d = (req_err || dmem_wr_en_i) ? 32'h0 :
                       load_extend(rd_word, dmem_byte_en_i, dmem_addr_i[1:0], dmem_zero_extend_i);
          if (LATENCY <= 1) begin
            state_d = ST_RESP;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = 2'(LATENCY - 1);
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 2'd1;
        if (cnt_q <= 2'd1) state_d = ST_RESP;
      end
      default: state_d = ST_IDLE;
    endcase
    // Outputs are registered and only carry data in the response cycle.
    if (state_d == ST_RESP) begin
      rvalid_d = 1'b1;
      rdata_d  = res_data_d;
      err_d    = res_err_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 2'd0;
      rvalid_q <= 1'b0;
      rdata_q  <= 32'h0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  // Held response payload; only meaningful while a request is in flight.
  always_ff @(posedge clk) begin
    res_data_q <= res_data_d;
    res_err_q  <= res_err_d;
  end

  // SRAM write port: stores commit at the grant edge, contents are not reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (lane_mask[b]) mem_q[word_idx][8*b +: 8] <= wdata_rep[8*b +: 8];
      end
    end
  end

  assign dmem_rvalid_o = rvalid_q;
  assign dmem_rdata_o  = rdata_q;
  assign dmem_err_o    = err_q;

endmodule

// File: tb/tb_sparrow_dmem_responder.sv
// Directed bench for sparrow_dmem_responder: three instances with LATENCY 1, 3
// and 4, each exercised through request/response transactions with
// hand-computed expected data, error flags and response latency.
module tb_sparrow_dmem_responder;

  localparam int LAT_OF [3] = '{1, 3, 4};

  logic        clk;
  logic        rst_n   [3];
  logic        req     [3];
  logic        gnt     [3];
  logic [31:0] addr    [3];
  logic        wr_en   [3];
  logic [1:0]  be      [3];
  logic        zx      [3];
  logic [31:0] wdata   [3];
  logic        rvalid  [3];
  logic [31:0] rdata   [3];
  logic        err     [3];

  int checks = 0;
  int errors = 0;

  sparrow_dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(1)) u_dut_l1 (
    .clk(clk), .rst_n(rst_n[0]), .dmem_req_i(req[0]), .dmem_gnt_o(gnt[0]),
    .dmem_addr_i(addr[0]), .dmem_wr_en_i(wr_en[0]), .dmem_byte_en_i(be[0]),
    .dmem_zero_extend_i(zx[0]), .dmem_wdata_i(wdata[0]), .dmem_rvalid_o(rvalid[0]),
    .dmem_rdata_o(rdata[0]), .dmem_err_o(err[0]));

  sparrow_dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(3)) u_dut_l3 (
    .clk(clk), .rst_n(rst_n[1]), .dmem_req_i(req[1]), .dmem_gnt_o(gnt[1]),
    .dmem_addr_i(addr[1]), .dmem_wr_en_i(wr_en[1]), .dmem_byte_en_i(be[1]),
    .dmem_zero_extend_i(zx[1]), .dmem_wdata_i(wdata[1]), .dmem_rvalid_o(rvalid[1]),
    .dmem_rdata_o(rdata[1]), .dmem_err_o(err[1]));

  sparrow_dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(4)) u_dut_l4 (
    .clk(clk), .rst_n(rst_n[2]), .dmem_req_i(req[2]), .dmem_gnt_o(gnt[2]),
    .dmem_addr_i(addr[2]), .dmem_wr_en_i(wr_en[2]), .dmem_byte_en_i(be[2]),
    .dmem_zero_extend_i(zx[2]), .dmem_wdata_i(wdata[2]), .dmem_rvalid_o(rvalid[2]),
    .dmem_rdata_o(rdata[2]), .dmem_err_o(err[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic r, input logic w, input logic [1:0] sz,
                         input logic z, input logic [31:0] a, input logic [31:0] d);
    req[i] = r; wr_en[i] = w; be[i] = sz; zx[i] = z; addr[i] = a; wdata[i] = d;
  endtask

  // One request: wait for grant, measure grant-to-rvalid latency, check payload,
  // then check the response pulse has ended.
  task automatic xact(input int i, input logic w, input logic [1:0] sz, input logic z,
                      input logic [31:0] a, input logic [31:0] d,
                      input logic [31:0] exp_d, input logic exp_e, input string tag);
    int waits;
    int lat;
    @(negedge clk);
    set_req(i, 1'b1, w, sz, z, a, d);
    #1;
    waits = 0;
    while (!gnt[i] && waits < 20) begin
      @(negedge clk); #1; waits++;
    end
    if (!gnt[i]) begin
      check_val({tag, "_gnt"}, 32'(gnt[i]), 32'd1);
      req[i] = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    req[i] = 1'b0;
    lat = 1;
    while (!rvalid[i] && lat < 10) begin
      @(negedge clk); lat++;
    end
    check_val({tag, "_lat"}, 32'(lat), 32'(LAT_OF[i]));
    check_val({tag, "_rdata"}, rdata[i], exp_d);
    check_val({tag, "_err"}, 32'(err[i]), {31'b0, exp_e});
    @(negedge clk);
    check_val({tag, "_idle"}, rdata[i] | {31'b0, rvalid[i] | err[i]}, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [11:0] g_obs, g_exp, r_obs, r_exp;
    int seen;
    for (int i = 0; i < 3; i++) begin
      rst_n[i] = 1'b1;
      set_req(i, 1'b0, 1'b0, 2'b11, 1'b0, 32'h0, 32'h0);
    end
    #1;
    for (int i = 0; i < 3; i++) rst_n[i] = 1'b0;
    req[0] = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check_val("rst_gnt", 32'(gnt[0]), 32'd0);
    check_val("rst_rvalid", {30'b0, rvalid[0], err[0]}, 32'h0);
    check_val("rst_rdata", rdata[0], 32'h0);
    req[0] = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) rst_n[i] = 1'b1;

    // Word store/load, LATENCY 1
    xact(0, 1'b1, 2'b11, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, "sw10");
    xact(0, 1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, "lw10");

    // Back-to-back store then load to the same word
    @(negedge clk);
    set_req(0, 1'b1, 1'b1, 2'b11, 1'b0, 32'h40, 32'hCAFEF00D);
    #1 check_val("b2b_gnt_st", 32'(gnt[0]), 32'd1);
    @(negedge clk);
    set_req(0, 1'b1, 1'b0, 2'b11, 1'b0, 32'h40, 32'h0);
    #1 check_val("b2b_gnt_ld", 32'(gnt[0]), 32'd1);
    check_val("b2b_st_rvalid", 32'(rvalid[0]), 32'd1);
    @(negedge clk);
    req[0] = 1'b0;
    check_val("b2b_ld_rvalid", 32'(rvalid[0]), 32'd1);
    check_val("b2b_ld_rdata", rdata[0], 32'hCAFEF00D);
    @(negedge clk);

    // Byte accesses
    xact(0, 1'b1, 2'b11, 1'b0, 32'h4, 32'h11223344, 32'h0, 1'b0, "sw4");
    xact(0, 1'b1, 2'b00, 1'b0, 32'h5, 32'hFFFFFFA5, 32'h0, 1'b0, "sb5");
    xact(0, 1'b0, 2'b00, 1'b0, 32'h5, 32'h0, 32'hFFFFFFA5, 1'b0, "lb5");
    xact(0, 1'b0, 2'b00, 1'b1, 32'h5, 32'h0, 32'h000000A5, 1'b0, "lbu5");
    xact(0, 1'b0, 2'b11, 1'b0, 32'h4, 32'h0, 32'h1122A544, 1'b0, "lw4");
    xact(0, 1'b0, 2'b00, 1'b1, 32'h7, 32'h0, 32'h00000011, 1'b0, "lbu7");
    xact(0, 1'b0, 2'b00, 1'b0, 32'h4, 32'h0, 32'h00000044, 1'b0, "lb4");

    // Half accesses
    xact(0, 1'b1, 2'b11, 1'b0, 32'h0, 32'h55667788, 32'h0, 1'b0, "sw0");
    xact(0, 1'b1, 2'b01, 1'b0, 32'h2, 32'h12348001, 32'h0, 1'b0, "sh2");
    xact(0, 1'b0, 2'b01, 1'b0, 32'h2, 32'h0, 32'hFFFF8001, 1'b0, "lh2");
    xact(0, 1'b0, 2'b01, 1'b1, 32'h2, 32'h0, 32'h00008001, 1'b0, "lhu2");
    xact(0, 1'b0, 2'b01, 1'b0, 32'h0, 32'h0, 32'h00007788, 1'b0, "lh0");
    xact(0, 1'b0, 2'b11, 1'b0, 32'h0, 32'h0, 32'h80017788, 1'b0, "lw0");
    xact(0, 1'b0, 2'b00, 1'b0, 32'h3, 32'h0, 32'hFFFFFF80, 1'b0, "lb3");
    xact(0, 1'b0, 2'b01, 1'b0, 32'h3, 32'h0, 32'h0, 1'b1, "lh3_err");
    xact(0, 1'b1, 2'b01, 1'b0, 32'h3, 32'h0000FFFF, 32'h0, 1'b1, "sh3_err");
    xact(0, 1'b0, 2'b11, 1'b0, 32'h0, 32'h0, 32'h80017788, 1'b0, "lw0_after");

    // Error cases and recovery
    xact(0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h0, 1'b1, "size10_err");
    xact(0, 1'b0, 2'b11, 1'b0, 32'h1000, 32'h0, 32'h0, 1'b1, "lw_oob_err");
    xact(0, 1'b1, 2'b11, 1'b0, 32'h1000, 32'h77777777, 32'h0, 1'b1, "sw_oob_err");
    xact(0, 1'b0, 2'b11, 1'b0, 32'h12, 32'h0, 32'h0, 1'b1, "lw_mis_err");
    xact(0, 1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, "lw10_again");
    xact(0, 1'b1, 2'b11, 1'b0, 32'hFFC, 32'h0F0F0F0F, 32'h0, 1'b0, "sw_top");
    xact(0, 1'b0, 2'b11, 1'b0, 32'hFFC, 32'h0, 32'h0F0F0F0F, 1'b0, "lw_top");

    // LATENCY 3 with request held high: grant every third cycle
    @(negedge clk);
    set_req(1, 1'b1, 1'b1, 2'b11, 1'b0, 32'h24, 32'hA1B2C3D4);
    for (int c = 0; c < 12; c++) begin
      #1;
      g_obs[c] = gnt[1];
      r_obs[c] = rvalid[1];
      g_exp[c] = (c % 3 == 0);
      r_exp[c] = (c >= 3) && (c % 3 == 0);
      @(negedge clk);
    end
    req[1] = 1'b0;
    check_val("l3_gnt_pattern", {20'b0, g_obs}, {20'b0, g_exp});
    check_val("l3_rvalid_pattern", {20'b0, r_obs}, {20'b0, r_exp});
    repeat (3) @(negedge clk);
    xact(1, 1'b1, 2'b11, 1'b0, 32'h20, 32'h12345678, 32'h0, 1'b0, "l3_sw20");
    xact(1, 1'b0, 2'b11, 1'b0, 32'h20, 32'h0, 32'h12345678, 1'b0, "l3_lw20");
    xact(1, 1'b0, 2'b11, 1'b0, 32'h24, 32'h0, 32'hA1B2C3D4, 1'b0, "l3_lw24");

    // LATENCY 4 with reset mid-operation
    xact(2, 1'b1, 2'b11, 1'b0, 32'h8, 32'h0BADC0DE, 32'h0, 1'b0, "l4_sw8");
    @(negedge clk);
    set_req(2, 1'b1, 1'b1, 2'b11, 1'b0, 32'hC, 32'h13572468);
    #1 check_val("l4_rst_gnt", 32'(gnt[2]), 32'd1);
    @(negedge clk);
    req[2] = 1'b0;
    @(negedge clk);
    rst_n[2] = 1'b0;
    #1;
    check_val("l4_rst_ctrl", {30'b0, rvalid[2], err[2]}, 32'h0);
    check_val("l4_rst_rdata", rdata[2], 32'h0);
    repeat (2) @(negedge clk);
    rst_n[2] = 1'b1;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (rvalid[2] || rdata[2] != 32'h0) seen++;
    end
    check_val("l4_no_rvalid_after_rst", 32'(seen), 32'd0);
    xact(2, 1'b0, 2'b11, 1'b0, 32'hC, 32'h0, 32'h13572468, 1'b0, "l4_lwC");
    xact(2, 1'b0, 2'b11, 1'b0, 32'h8, 32'h0, 32'h0BADC0DE, 1'b0, "l4_lw8");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
